// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient
// and remainder, one quotient bit per clock, valid/ready on both sides.
// Optional macro DIV_SIGNED_EN selects two's-complement operands, with one
// extra sign fix-up cycle.
module seq_divider #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero,
    output logic                 overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_q;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_zero;
    logic               r_overflow;

    logic [2*WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic               w_is_zero;
    logic               w_is_ovf;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_last;
    logic               w_accept;

`ifdef DIV_SIGNED_EN
    logic               r_neg_q;
    logic               r_neg_r;
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_lim;
    logic               w_fix_ovf;

    // Convert operands to magnitudes; the core always divides unsigned values.
    always_comb begin
        w_dvd_neg = dividend[2*WIDTH-1];
        w_dvs_neg = divisor[WIDTH-1];
        w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
        w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;
    end

    // Largest representable magnitude: 2^(W-1) for a negative quotient, else 2^(W-1)-1.
    always_comb begin
        w_lim     = {1'b0, {(WIDTH-1){1'b1}}} + {{(WIDTH-1){1'b0}}, r_neg_q};
        w_fix_ovf = (r_q > w_lim);
    end
`else
    // Unsigned build: operands are already magnitudes.
    always_comb begin
        w_dvd_mag = dividend;
        w_dvs_mag = divisor;
    end
`endif

    // Operand screening and one restoring-division step.
    always_comb begin
        w_accept  = in_valid && (r_state == IDLE);
        w_is_zero = (divisor == '0);
        w_is_ovf  = !w_is_zero && (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dvs_mag);
        w_shift   = {r_rem, r_lo[WIDTH-1]};
        w_diff    = w_shift - {1'b0, r_dvs};
        // Shifted R is below 2*divisor, so the difference fits and bit WIDTH is its sign.
        w_ge      = !w_diff[WIDTH];
        w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
        w_last    = (r_cnt == CW'(WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_nxt = (w_is_zero || w_is_ovf) ? DONE : BUSY;
`ifdef DIV_SIGNED_EN
            BUSY: if (w_last) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
`else
            BUSY: if (w_last) w_state_nxt = DONE;
            FIX:  w_state_nxt = IDLE;
`endif
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_lo        <= '0;
            r_dvs       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_dvs <= w_dvs_mag;
                r_rem <= w_dvd_mag[2*WIDTH-1:WIDTH];
                r_lo  <= w_dvd_mag[WIDTH-1:0];
                r_q   <= '0;
                r_cnt <= '0;
`ifdef DIV_SIGNED_EN
                r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                r_neg_r <= w_dvd_neg;
`endif
                if (w_is_zero) begin
                    r_quotient  <= '1;
                    r_remainder <= dividend[WIDTH-1:0];
                    r_div_zero  <= 1'b1;
                    r_overflow  <= 1'b0;
                end else if (w_is_ovf) begin
                    r_quotient  <= '1;
                    r_remainder <= '0;
                    r_div_zero  <= 1'b0;
                    r_overflow  <= 1'b1;
                end else begin
                    r_quotient  <= '0;
                    r_remainder <= '0;
                    r_div_zero  <= 1'b0;
                    r_overflow  <= 1'b0;
                end
            end
            if (r_state == BUSY) begin
                r_rem <= w_rem_nxt;
                r_lo  <= {r_lo[WIDTH-2:0], 1'b0};
                r_q   <= w_q_nxt;
                r_cnt <= r_cnt + 1'b1;
`ifndef DIV_SIGNED_EN
                if (w_last) begin
                    r_quotient  <= w_q_nxt;
                    r_remainder <= w_rem_nxt;
                end
`endif
            end
`ifdef DIV_SIGNED_EN
            if (r_state == FIX) begin
                r_overflow  <= w_fix_ovf;
                r_quotient  <= w_fix_ovf ? '1 : (r_neg_q ? (~r_q + 1'b1) : r_q);
                r_remainder <= w_fix_ovf ? '0 : (r_neg_r ? (~r_rem + 1'b1) : r_rem);
            end
`endif
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;
    assign overflow  = r_overflow;

endmodule
